// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift unit: mode encodings and FSM states.
package shift_pkg;

  localparam logic [2:0] MODE_LOAD = 3'b000;
  localparam logic [2:0] MODE_SLL  = 3'b001;
  localparam logic [2:0] MODE_SRL  = 3'b010;
  localparam logic [2:0] MODE_SRA  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_SLS  = 3'b110;
  localparam logic [2:0] MODE_SRS  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One single-bit shift step of the selected mode. Purely combinational so the
// same step can be chained or reused by other shifter variants.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);

  // Next register value and the bit leaving the register for one step.
  // LOAD is not a shift; it holds q and reports 0 as the out bit.
  always_comb begin
    q_next  = q;
    out_bit = 1'b0;
    unique case (mode)
      MODE_SLL: begin
        q_next  = {q[WIDTH-2:0], 1'b0};
        out_bit = q[WIDTH-1];
      end
      MODE_SRL: begin
        q_next  = {1'b0, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_SRA: begin
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_ROL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      MODE_ROR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      MODE_SLS: begin
        q_next  = {q[WIDTH-2:0], serial_in};
        out_bit = q[WIDTH-1];
      end
      MODE_SRS: begin
        q_next  = {serial_in, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        q_next  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_unit.sv
// Multi-cycle universal shift register with start/busy/done handshake.
// Shifts one bit per clock for a run-time amount; LOAD replaces q directly.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; captures mode/amount, performs LOAD
//   ST_SHIFT | one shift step per cycle until cnt reaches zero
//   ST_DONE  | one-cycle completion pulse, result valid, start ignored
module universal_shift_unit
  import shift_pkg::*;
#(
  parameter  int WIDTH   = 16,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         mode,
  input  logic [SHAMT_W-1:0] amount,
  input  logic [WIDTH-1:0]   load,
  input  logic               serial_in,
  output logic [WIDTH-1:0]   q,
  output logic               serial_out,
  output logic               busy,
  output logic               done,
  output logic               zero
);

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  state_t             state;
  state_t             state_next;
  logic [SHAMT_W-1:0] cnt;
  logic [2:0]         mode_r;
  logic [WIDTH-1:0]   step_q;
  logic               step_out;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .q        (q),
    .mode     (mode_r),
    .serial_in(serial_in),
    .q_next   (step_q),
    .out_bit  (step_out)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode; LOAD and zero amount skip straight to DONE.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (mode == MODE_LOAD || amount == '0) state_next = ST_DONE;
          else                                   state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == CNT_ONE) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Datapath: capture the request in IDLE, apply one step per SHIFT cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q          <= '0;
      serial_out <= 1'b0;
      cnt        <= '0;
      mode_r     <= MODE_LOAD;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            mode_r <= mode;
            cnt    <= amount;
            if (mode == MODE_LOAD) begin
              q          <= load;
              serial_out <= 1'b0;
            end
          end
        end
        ST_SHIFT: begin
          q          <= step_q;
          serial_out <= step_out;
          cnt        <= cnt - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  // Handshake flags come straight from the state register.
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);
  assign zero = (q == '0);

endmodule

// File: doc/universal_shift_unit.md
# universal_shift_unit

Parametrised multi-cycle universal shift register with a start/busy/done handshake. It generalises the fixed serial shift register to configurable width and eight modes: load, logical, arithmetic, rotate and serial-fill shifts, by a run-time amount. Shifting proceeds one bit per clock, which keeps the datapath small. The ALU uses it for shift/rotate instructions and for normalisation steps that follow the leading-zero counter.

## Interface
- WIDTH, 16, register width in bits; must be at least 2.
- SHAMT_W, $clog2(WIDTH), width of the shift amount; derived localparam, not overridable.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- mode  in  3  operation select; captured on accepted start.
- amount  in  SHAMT_W  number of single-bit shifts; captured on accepted start.
- load  in  WIDTH  parallel load value, used by LOAD mode.
- serial_in  in  1  fill bit for SLS/SRS; sampled on every shift cycle.
- q  out  WIDTH  register contents.
- serial_out  out  1  bit shifted or rotated out by the most recent shift.
- busy  out  1  high while an operation is in progress.
- done  out  1  single-cycle completion pulse.
- zero  out  1  combinational, equals (q == 0).

## Operation
- Mode encoding:
  - 000 LOAD.
  - 001 SLL: shift left, fill 0.
  - 010 SRL: shift right, fill 0.
  - 011 SRA: shift right, fill with q[WIDTH-1].
  - 100 ROL: rotate left.
  - 101 ROR: rotate right.
  - 110 SLS: shift left, fill serial_in.
  - 111 SRS: shift right, fill serial_in.
- Shifts always operate on the current q. Load the operand first with a LOAD operation.
- FSM states and transitions:
  - IDLE: on start=1, latch mode into mode_r and amount into cnt.
    - If mode is LOAD: q <= load, serial_out <= 0, go to DONE.
    - Else if amount is 0: go to DONE with q unchanged.
    - Else: go to SHIFT.
  - SHIFT: each cycle apply one step of mode_r and decrement cnt. The step at which cnt goes 1→0 is the last one; go to DONE.
  - DONE: done=1 for this cycle, then go to IDLE unconditionally.
- serial_out per shift step:
  - Left modes (SLL, ROL, SLS): the old q[WIDTH-1].
  - Right modes (SRL, SRA, ROR, SRS): the old q[0].
- serial_out holds its value between shifts.
- The amount value is taken literally; no clamping. With a non-power-of-two WIDTH, an amount ≥ WIDTH simply performs that many shifts.
- When busy=1, start, mode, amount and load are ignored. There is no queueing.
- serial_in is sampled at every SHIFT edge, not captured at start.

## Timing
- Reset (asynchronous, any state, including mid-SHIFT):
  - q=0, serial_out=0, busy=0, done=0, cnt=0, state IDLE.
  - zero=1 follows from q=0.
  - An operation interrupted by reset never produces done.
- Latency: start high in cycle 0 means done high in cycle amount+1. LOAD and amount=0 complete in cycle 1.
- The final q and serial_out are valid in the done cycle and hold until the next operation.
- busy is high in cycles 1 through amount+1, including the done cycle. The earliest next accepted start is cycle amount+2.
- done and busy are registered outputs (decoded from state register). No combinational path from inputs to busy or done.
- start held high continuously triggers back-to-back operations, one every amount+2 cycles.

## Structure
- Shared package/header shift_pkg holds:
  - MODE_LOAD … MODE_SRS localparams.
  - State encodings ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module shift_step (combinational):
  - Inputs: q, mode, serial_in.
  - Outputs: the next q and the out bit.
  - Instantiated once. It is reused later by a barrel-shift variant.
- The top level holds the FSM, cnt, q, mode_r and serial_out registers.

## Test plan
All scenarios use WIDTH=8.

- Reset: hold reset=0 → q=8'h00, busy=0, done=0, serial_out=0, zero=1.
- LOAD: start, mode=000, load=8'hB4 → in cycle 1, q=8'hB4, done=1, busy=1. In cycle 2, busy=0.
- SRA: from q=8'hB4, start, mode=011, amount=3 → q goes DA, ED, F6. done in cycle 4, q=8'hF6, serial_out=1.
- ROL: from q=8'hB4, start, mode=100, amount=4 → done in cycle 5, q=8'h4B, serial_out=1. A start pulsed in cycles 2–5 with mode=000, load=8'hFF is ignored and q stays 8'h4B.
- Zero amount and SLS fill:
  - mode=001, amount=0 → done in cycle 1, q unchanged.
  - Then mode=110, amount=2 with serial_in=1 both cycles, from q=8'h4B → q=8'h2F.
- Reset mid-operation: SRL with amount=5, assert reset in cycle 3 → q=0 and busy=0 immediately, no done pulse. After release, a new LOAD of 8'h01 completes normally.
